// File: rtl/sensor_clk_gen_if.sv
// rtl/sensor_clk_gen_if.sv - configuration, control and clock-output bundle for sensor_clk_gen
interface sensor_clk_gen_if #(
  parameter int NCH   = 2,
  parameter int DIV_W = 8,
  parameter int CNT_W = 16,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_mode;
  logic [CNT_W-1:0] cfg_burst;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   stop;
  logic [NCH-1:0]   clk_lvl;
  logic [NCH-1:0]   rise;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;

  modport master (
    output cfg_wr, cfg_ch, cfg_half, cfg_mode, cfg_burst, start, stop,
    input  clk_lvl, rise, busy, done
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_half, cfg_mode, cfg_burst, start, stop,
    output clk_lvl, rise, busy, done
  );
endinterface

// File: rtl/sensor_clk_gen.sv
// rtl/sensor_clk_gen.sv - per-channel programmable sensor clock generator
// Each channel runs continuous or counted-burst 50% duty clocks from clk_100.
module sensor_clk_gen #(
  parameter int NCH          = 2,
  parameter int DIV_W        = 8,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 10
) (
  input  logic            clk_100,
  input  logic            Reset,
  sensor_clk_gen_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [NCH-1:0] lvl_v;
  logic [NCH-1:0] rise_v;
  logic [NCH-1:0] busy_v;
  logic [NCH-1:0] done_v;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t           state, state_n;
    logic [DIV_W-1:0] cfg_half_q, eff_half;
    logic             cfg_mode_q;
    logic [CNT_W-1:0] cfg_burst_q;
    logic [DIV_W-1:0] w_half, w_half_n;
    logic             w_mode, w_mode_n;
    logic [CNT_W-1:0] w_burst, w_burst_n;
    logic [DIV_W-1:0] half_cnt, half_cnt_n;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_n;
    logic             lvl, lvl_n;
    logic             rise_q, rise_n;
    logic             done_q, done_n;
    logic             cfg_sel, go, finish;

    assign cfg_sel  = bus.cfg_wr && (bus.cfg_ch == CH_W'(i));
    assign eff_half = (cfg_half_q == '0) ? DIV_W'(1) : cfg_half_q;
    assign go       = bus.start[i] && !bus.stop[i];

    always_ff @(posedge clk_100 or posedge Reset) begin
      if (Reset) begin
        cfg_half_q  <= DIV_W'(DEFAULT_HALF);
        cfg_mode_q  <= 1'b0;
        cfg_burst_q <= CNT_W'(1);
      end else if (cfg_sel) begin
        cfg_half_q  <= bus.cfg_half;
        cfg_mode_q  <= bus.cfg_mode;
        cfg_burst_q <= bus.cfg_burst;
      end
    end

    // half_cnt holds the cycles still to go in the current phase after this one
    always_comb begin
      state_n     = state;
      lvl_n       = lvl;
      half_cnt_n  = half_cnt;
      burst_cnt_n = burst_cnt;
      w_half_n    = w_half;
      w_mode_n    = w_mode;
      w_burst_n   = w_burst;
      rise_n      = 1'b0;
      done_n      = 1'b0;
      finish      = 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            w_half_n  = eff_half;
            w_mode_n  = cfg_mode_q;
            w_burst_n = cfg_burst_q;
            if (cfg_mode_q && (cfg_burst_q == '0)) begin
              done_n = 1'b1;
            end else begin
              state_n     = RUN;
              lvl_n       = 1'b1;
              rise_n      = 1'b1;
              half_cnt_n  = eff_half - DIV_W'(1);
              burst_cnt_n = CNT_W'(1);
            end
          end
        end
        RUN, DRAIN: begin
          if (half_cnt != '0) begin
            half_cnt_n = half_cnt - DIV_W'(1);
            if ((state == RUN) && bus.stop[i]) begin
              if (lvl) state_n = DRAIN;
              else     finish  = 1'b1;
            end
          end else if (lvl) begin
            lvl_n      = 1'b0;
            half_cnt_n = w_half - DIV_W'(1);
            if ((state == DRAIN) || bus.stop[i]) finish = 1'b1;
          end else if (bus.stop[i] || (w_mode && (burst_cnt == w_burst))) begin
            finish = 1'b1;
          end else begin
            lvl_n      = 1'b1;
            rise_n     = 1'b1;
            half_cnt_n = w_half - DIV_W'(1);
            if (w_mode) burst_cnt_n = burst_cnt + CNT_W'(1);
          end
          // a stopped high phase still finishes, so the last fall coincides with done
          if (finish) begin
            state_n     = IDLE;
            lvl_n       = 1'b0;
            done_n      = 1'b1;
            half_cnt_n  = '0;
            burst_cnt_n = '0;
          end
        end
        default: begin
          state_n     = IDLE;
          lvl_n       = 1'b0;
          half_cnt_n  = '0;
          burst_cnt_n = '0;
        end
      endcase
    end

    always_ff @(posedge clk_100 or posedge Reset) begin
      if (Reset) begin
        state     <= IDLE;
        lvl       <= 1'b0;
        rise_q    <= 1'b0;
        done_q    <= 1'b0;
        half_cnt  <= '0;
        burst_cnt <= '0;
        w_half    <= '0;
        w_mode    <= 1'b0;
        w_burst   <= '0;
      end else begin
        state     <= state_n;
        lvl       <= lvl_n;
        rise_q    <= rise_n;
        done_q    <= done_n;
        half_cnt  <= half_cnt_n;
        burst_cnt <= burst_cnt_n;
        w_half    <= w_half_n;
        w_mode    <= w_mode_n;
        w_burst   <= w_burst_n;
      end
    end

    assign lvl_v[i]  = lvl;
    assign rise_v[i] = rise_q;
    assign busy_v[i] = (state != IDLE);
    assign done_v[i] = done_q;
  end

  assign bus.clk_lvl = lvl_v;
  assign bus.rise    = rise_v;
  assign bus.busy    = busy_v;
  assign bus.done    = done_v;
endmodule

// File: tb/tb_sensor_clk_gen.sv
// tb/tb_sensor_clk_gen.sv - table, sequence and randomized model checks for sensor_clk_gen
module tb_sensor_clk_gen;
  localparam int NCH   = 2;
  localparam int DIV_W = 8;
  localparam int CNT_W = 16;
  localparam int TMAX  = 600;
  localparam int INF   = 1 << 30;

  logic clk_100 = 1'b0;
  logic Reset   = 1'b1;

  sensor_clk_gen_if #(.NCH(NCH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  sensor_clk_gen #(.NCH(NCH), .DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_HALF(10)) dut (
    .clk_100 (clk_100),
    .Reset   (Reset),
    .bus     (bus.slave)
  );

  always #5 clk_100 = ~clk_100;

  int checks = 0;
  int errors = 0;

  logic tr_lvl  [TMAX];
  logic tr_rise [TMAX];
  logic tr_busy [TMAX];
  logic tr_done [TMAX];

  typedef struct {
    int ch; int half; int mode; int burst; int stop_at;
    int exp_rises; int exp_highs; int exp_done;
  } vec_t;
  vec_t vecs[$];

  int m_s[NCH], m_e[NCH], m_h[NCH];
  int c_half[NCH], c_mode[NCH], c_burst[NCH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_half = '0; bus.cfg_mode = 1'b0;
    bus.cfg_burst = '0; bus.start = '0; bus.stop = '0;
  endtask

  task automatic cfg_write(input int ch, input int half, input int mode, input int burst);
    bus.cfg_wr = 1'b1; bus.cfg_ch = 1'(ch); bus.cfg_half = 8'(half);
    bus.cfg_mode = 1'(mode); bus.cfg_burst = 16'(burst);
    @(negedge clk_100);
    bus.cfg_wr = 1'b0;
  endtask

  // start[ch] is driven in cycle 0 (the current negedge); samples cycles 1..ncyc-1
  task automatic trace(input int ch, input int ncyc, input int stop_at, input int wr_at, input int wr_half);
    tr_lvl[0] = bus.clk_lvl[ch]; tr_rise[0] = bus.rise[ch];
    tr_busy[0] = bus.busy[ch];   tr_done[0] = bus.done[ch];
    bus.start[ch] = 1'b1;
    for (int k = 1; k < ncyc; k++) begin
      @(negedge clk_100);
      bus.start = '0;
      bus.cfg_wr = 1'b0;
      bus.stop[ch] = (k == stop_at);
      if (k == wr_at) begin
        bus.cfg_wr = 1'b1; bus.cfg_ch = 1'(ch); bus.cfg_half = 8'(wr_half);
        bus.cfg_mode = 1'b0; bus.cfg_burst = 16'(1);
      end
      tr_lvl[k] = bus.clk_lvl[ch]; tr_rise[k] = bus.rise[ch];
      tr_busy[k] = bus.busy[ch];   tr_done[k] = bus.done[ch];
    end
    bus.stop = '0;
    bus.cfg_wr = 1'b0;
  endtask

  function automatic int count_rise(input int n);
    int c = 0;
    for (int k = 1; k < n; k++) if (tr_rise[k]) c++;
    return c;
  endfunction

  function automatic int count_high(input int n);
    int c = 0;
    for (int k = 1; k < n; k++) if (tr_lvl[k]) c++;
    return c;
  endfunction

  function automatic int first_done(input int n);
    for (int k = 1; k < n; k++) if (tr_done[k]) return k;
    return -1;
  endfunction

  task automatic wait_done(input int ch, input string name);
    int found = 0;
    bus.stop[ch] = 1'b1;
    for (int k = 0; k < TMAX && found == 0; k++) begin
      @(negedge clk_100);
      bus.stop = '0;
      if (bus.done[ch]) found = 1;
    end
    chk(name, found, 1);
    chk({name, "_busy"}, bus.busy[ch], 0);
  endtask

  task automatic do_reset();
    @(negedge clk_100);
    Reset = 1'b1;
    idle_inputs();
    @(negedge clk_100);
    @(negedge clk_100);
    Reset = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    idle_inputs();
    repeat (3) @(negedge clk_100);
    chk("rst_lvl_during", bus.clk_lvl, 0);
    chk("rst_busy_during", bus.busy, 0);
    Reset = 1'b0;
    @(negedge clk_100);
    chk("rst_lvl", bus.clk_lvl, 0);
    chk("rst_rise", bus.rise, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    // default 10-cycle half period straight out of reset
    trace(0, 46, -1, -1, 0);
    chk("def_rise1", tr_rise[1], 1);
    chk("def_rise21", tr_rise[21], 1);
    chk("def_rise41", tr_rise[41], 1);
    chk("def_rises", count_rise(46), 3);
    chk("def_lvl10", tr_lvl[10], 1);
    chk("def_lvl11", tr_lvl[11], 0);
    chk("def_lvl20", tr_lvl[20], 0);
    chk("def_busy1", tr_busy[1], 1);
    wait_done(0, "def_stop_done");

    // config write while running leaves the running period alone
    trace(0, 46, -1, 5, 5);
    chk("wr_lvl11", tr_lvl[11], 0);
    chk("wr_lvl15", tr_lvl[15], 0);
    chk("wr_rise21", tr_rise[21], 1);
    chk("wr_rises", count_rise(46), 3);
    wait_done(0, "wr_stop_done");
    trace(0, 24, -1, -1, 0);
    chk("new_lvl5", tr_lvl[5], 1);
    chk("new_lvl6", tr_lvl[6], 0);
    chk("new_rise11", tr_rise[11], 1);
    chk("new_rises", count_rise(24), 3);
    wait_done(0, "new_stop_done");

    // start together with stop in idle is ignored
    bus.start[1] = 1'b1; bus.stop[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100);
      bus.start = '0; bus.stop = '0;
      chk("startstop_busy", bus.busy[1], 0);
      chk("startstop_lvl", bus.clk_lvl[1], 0);
    end

    vecs.push_back('{0, 10, 0, 1,  3, 1, 10,  11});
    vecs.push_back('{1,  3, 1, 4, -1, 4, 12,  25});
    vecs.push_back('{0,  0, 1, 2, -1, 2,  2,   5});
    vecs.push_back('{1,  5, 1, 0, -1, 0,  0,   1});
    vecs.push_back('{0,  4, 0, 1,  6, 1,  4,   7});
    vecs.push_back('{1,  2, 1, 3,  2, 1,  2,   3});
    vecs.push_back('{0,255, 1, 1, -1, 1,255, 511});
    vecs.push_back('{1,  1, 0, 1,  4, 2,  2,   5});
    for (int v = 0; v < vecs.size(); v++) begin
      cfg_write(vecs[v].ch, vecs[v].half, vecs[v].mode, vecs[v].burst);
      trace(vecs[v].ch, 560, vecs[v].stop_at, -1, 0);
      d = first_done(560);
      chk($sformatf("vec%0d_rises", v), count_rise(560), vecs[v].exp_rises);
      chk($sformatf("vec%0d_highs", v), count_high(560), vecs[v].exp_highs);
      chk($sformatf("vec%0d_done", v), d, vecs[v].exp_done);
      if (d > 0) chk($sformatf("vec%0d_busy_at_done", v), tr_busy[d], 0);
      chk($sformatf("vec%0d_busy_end", v), bus.busy[vecs[v].ch], 0);
    end

    // asynchronous reset in the middle of a high phase on both channels
    cfg_write(0, 6, 0, 1);
    cfg_write(1, 7, 0, 1);
    bus.start = '1;
    @(negedge clk_100); bus.start = '0;
    @(negedge clk_100);
    @(negedge clk_100);
    chk("pre_rst_lvl", bus.clk_lvl, 3);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_lvl", bus.clk_lvl, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_rise", bus.rise, 0);
    chk("async_rst_done", bus.done, 0);
    @(negedge clk_100);
    Reset = 1'b0;
    bus.start[1] = 1'b1;
    trace(0, 24, -1, -1, 0);
    chk("post_rst_lvl10", tr_lvl[10], 1);
    chk("post_rst_lvl11", tr_lvl[11], 0);
    chk("post_rst_rise21", tr_rise[21], 1);
    chk("post_rst_ch1_busy", bus.busy[1], 1);
    bus.stop[1] = 1'b1;
    wait_done(0, "post_rst_done");
    chk("post_rst_all_idle", bus.busy, 0);

    // randomized traffic against a schedule-based reference
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      m_s[c] = 0; m_e[c] = -1; m_h[c] = 1;
      c_half[c] = 10; c_mode[c] = 0; c_burst[c] = 1;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [NCH-1:0] st, sp;
      int wr, wch, whalf, wmode, wburst;
      @(negedge clk_100);
      for (int c = 0; c < NCH; c++) begin
        int ph, el, er, eb, ed;
        eb = (cyc >= m_s[c]) && (cyc < m_e[c]);
        ph = cyc - m_s[c];
        el = eb && (((ph / m_h[c]) % 2) == 0);
        er = eb && ((ph % (2 * m_h[c])) == 0);
        ed = (cyc == m_e[c]);
        chk($sformatf("rnd_lvl ch%0d cyc%0d", c, cyc), bus.clk_lvl[c], el);
        chk($sformatf("rnd_rise ch%0d cyc%0d", c, cyc), bus.rise[c], er);
        chk($sformatf("rnd_busy ch%0d cyc%0d", c, cyc), bus.busy[c], eb);
        chk($sformatf("rnd_done ch%0d cyc%0d", c, cyc), bus.done[c], ed);
      end
      for (int c = 0; c < NCH; c++) begin
        st[c] = ($urandom_range(0, 5) == 0);
        sp[c] = ($urandom_range(0, 11) == 0);
      end
      wr = ($urandom_range(0, 9) == 0);
      wch = $urandom_range(0, NCH - 1);
      whalf = $urandom_range(0, 4);
      wmode = $urandom_range(0, 1);
      wburst = $urandom_range(0, 3);
      bus.start = st; bus.stop = sp;
      bus.cfg_wr = 1'(wr); bus.cfg_ch = 1'(wch); bus.cfg_half = 8'(whalf);
      bus.cfg_mode = 1'(wmode); bus.cfg_burst = 16'(wburst);
      for (int c = 0; c < NCH; c++) begin
        int active, ph, ne;
        active = (cyc >= m_s[c]) && (cyc < m_e[c]);
        ph = cyc - m_s[c];
        if (active && sp[c]) begin
          if (((ph / m_h[c]) % 2) == 0) ne = m_s[c] + (ph / m_h[c] + 1) * m_h[c];
          else                          ne = cyc + 1;
          if (ne < m_e[c]) m_e[c] = ne;
        end else if (!active && st[c] && !sp[c]) begin
          m_s[c] = cyc + 1;
          m_h[c] = (c_half[c] == 0) ? 1 : c_half[c];
          m_e[c] = c_mode[c] ? m_s[c] + 2 * m_h[c] * c_burst[c] : INF;
        end
        if (wr && wch == c) begin
          c_half[c] = whalf; c_mode[c] = wmode; c_burst[c] = wburst;
        end
      end
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
